user_event_snapshot: RTL

// Counts qualified events in the user_clk domain and presents a coherent, held-stable 32-bit

---
 rtl/user_status_pkg.sv | 16 +
 rtl/user_event_snapshot_if.sv | 23 ++
 rtl/user_event_snapshot_sat_counter.sv | 32 +++
 rtl/user_event_snapshot.sv | 131 +++++++++++++
 4 files changed

// File: rtl/user_status_pkg.sv
// Shared definitions for the user-clock status counters feeding OPB status registers.
package user_status_pkg;

  localparam int STATUS_DW = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } snap_state_t;

  // Tag field fills whatever the counter and the ovf bit leave of the 32-bit word.
  function automatic int TAG_W(input int cnt_width);
    return 31 - cnt_width;
  endfunction

endpackage

// File: rtl/user_event_snapshot_if.sv
// Event/snapshot control and status word between user logic and the snapshot block.
interface user_event_snapshot_if;
  import user_status_pkg::*;

  logic                 event_in;
  logic                 event_en;
  logic                 snap_req;
  logic                 clr;
  logic [STATUS_DW-1:0] user_data_out;
  logic                 snap_busy;
  logic                 snap_done;

  modport master (
    output event_in, event_en, snap_req, clr,
    input  user_data_out, snap_busy, snap_done
  );

  modport slave (
    input  event_in, event_en, snap_req, clr,
    output user_data_out, snap_busy, snap_done
  );

endinterface

// File: rtl/user_event_snapshot_sat_counter.sv
// Saturating up-counter with sticky overflow; shared by the user-domain status counters.
module sat_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             reload,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic at_max;

  assign at_max = &count;

  // clr and reload both restart from zero; reload is the capture-driven restart.
  always_ff @(posedge clk) begin
    if (rst || clr || reload) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf <= 1'b1;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/user_event_snapshot.sv
// Event counter with a held-stable, tagged 32-bit snapshot word for a CDC status register.
//   state   | meaning
//   ST_IDLE | word stable, waiting for snap_req
//   ST_HOLD | word just updated, must stay unchanged for HOLD_CYCLES cycles
module user_event_snapshot
  import user_status_pkg::*;
#(
  parameter int CNT_WIDTH   = 24,
  parameter int HOLD_CYCLES = 8,
  parameter bit CLR_ON_SNAP = 1'b0
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  user_event_snapshot_if.slave  bus
);

  localparam int                TW        = TAG_W(CNT_WIDTH);
  localparam int                HW        = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  snap_state_t          state;
  snap_state_t          state_nxt;
  logic                 capture;
  logic [HW-1:0]        hold_cnt;
  logic                 pending;
  logic [TW-1:0]        tag;
  logic [CNT_WIDTH-1:0] snap_cnt;
  logic                 word_ovf;
  logic                 snap_done;
  logic                 snap_busy;

  logic                 ev;
  logic [CNT_WIDTH-1:0] live_cnt;
  logic                 live_ovf;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 ovf_nxt;

  assign ev = bus.event_in & bus.event_en;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk    (user_clk),
    .rst    (user_rst),
    .inc    (ev),
    .clr    (bus.clr),
    .reload (capture && CLR_ON_SNAP),
    .count  (live_cnt),
    .ovf    (live_ovf)
  );

  // Pre-clear next value, so a capture includes an event (and an overflow) in its own cycle.
  always_comb begin
    cnt_nxt = live_cnt;
    ovf_nxt = live_ovf;
    if (ev) begin
      if (&live_cnt) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = live_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.snap_req) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) begin
          if (pending || bus.snap_req) begin
            capture = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      hold_cnt  <= '0;
      pending   <= 1'b0;
      tag       <= '0;
      snap_cnt  <= '0;
      word_ovf  <= 1'b0;
      snap_done <= 1'b0;
      snap_busy <= 1'b0;
    end else begin
      snap_done <= capture;
      snap_busy <= (state_nxt == ST_HOLD);

      if (capture) begin
        hold_cnt <= HOLD_LOAD;
        tag      <= tag + TW'(1);
        snap_cnt <= cnt_nxt;
        word_ovf <= ovf_nxt;
      end else if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt - HW'(1);
      end

      // One-deep: any number of requests inside the window yield a single follow-up word.
      if (capture) begin
        pending <= 1'b0;
      end else if (state == ST_HOLD && bus.snap_req) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.user_data_out = {word_ovf, tag, snap_cnt};
  assign bus.snap_busy     = snap_busy;
  assign bus.snap_done     = snap_done;

endmodule
